ternary_seq_ctrl: RTL and testbench
===================================

TERNARY_SEQ_CTRL -- requirements
Module: ternary_seq_ctrl

Interface
REQ-001 SHALL have parameter MAX_IN_LEN, default 16: activation vector width (ternary weight rows).
REQ-002 SHALL have parameter MAX_OUT_LEN, default 8: number of weight columns / result columns.
REQ-003 SHALL have ports, in this order:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  command strobe, sampled in IDLE only
- mode  in  1  0 = LOAD weights, 1 = RUN inference
- abort  in  1  synchronous cancel
- cfg_in_len  in  4  active rows
- cfg_out_last  in  3  last column index (columns = value+1)
- cfg_vec_last  in  4  last vector index (vectors = value+1)
- load_ena  out  1  enable to the weight loader, one beat per cycle
- weights_valid  out  1  a complete weight load has finished
- act_valid  in  1  activation vector offered
- act_ready  out  1  controller accepts the activation vector
- mac_clear  out  1  clear the accumulators
- mac_en  out  1  accumulate the column at col_idx
- col_idx  out  3  column being accumulated
- res_valid  out  1  result column offered
- res_ready  in  1  consumer accepts the result
- res_col  out  3  column index of the offered result
- busy  out  1  not in IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle command-error pulse

Function
REQ-004 SHALL implement the states IDLE, LOAD, ACCEPT, MAC and EMIT; every output SHALL be registered.
REQ-005 SHALL latch cfg_in_len, cfg_out_last and cfg_vec_last on an accepted start and hold them until the next accepted start; cfg changes mid-operation SHALL have no effect.
REQ-006 In IDLE, start=1 with mode=0 SHALL go to LOAD and clear weights_valid in the same edge.
REQ-007 In IDLE, start=1 with mode=1 and weights_valid=1 SHALL go to ACCEPT with the vector counter set to 0.
REQ-008 In IDLE, start=1 with mode=1 and weights_valid=0 SHALL pulse err for exactly one cycle and stay in IDLE.
REQ-009 start SHALL be ignored outside IDLE.
REQ-010 LOAD SHALL hold load_ena=1 for exactly 2*(cfg_out_last+1) consecutive cycles, starting the cycle after start: an MSB beat then an LSB beat per column, column 0 first.
REQ-011 On leaving LOAD, the controller SHALL go to IDLE, set weights_valid=1 and pulse done in the same cycle that load_ena falls.
REQ-012 ACCEPT SHALL drive act_ready=1.
- On act_valid && act_ready: mac_clear=1 for exactly that cycle, then go to MAC.
- act_ready SHALL be 0 in every other state.
REQ-013 MAC SHALL hold mac_en=1 for cfg_out_last+1 cycles, with col_idx = 0, 1, …, cfg_out_last (one per cycle), then go to EMIT. Outside MAC, col_idx SHALL be 0.
REQ-014 EMIT SHALL drive res_valid=1 with res_col starting at 0.
- res_col SHALL be held stable while res_valid && !res_ready.
- res_col SHALL advance by 1 on each handshake.
- res_valid SHALL never drop without a handshake, except on abort.
REQ-015 On the handshake for res_col == cfg_out_last:
- if the vector counter == cfg_vec_last: go to IDLE and pulse done;
- otherwise: increment the vector counter and return to ACCEPT.
REQ-016 Back-to-back vectors: act_ready SHALL rise the cycle after the final EMIT handshake.
REQ-017 abort=1 SHALL force IDLE at the next edge from any state.
- Deassert load_ena, act_ready, mac_en, mac_clear and res_valid.
- No done or err pulse.
- Clear weights_valid if abort occurs in LOAD; otherwise leave it unchanged.
- abort SHALL take priority over start.
REQ-018 busy SHALL be 1 exactly when the state is not IDLE.
REQ-019 Counters SHALL not wrap: cfg_out_last=7 gives 16 load beats and 8 MAC cycles; cfg_vec_last=15 gives 16 vectors.

Reset
REQ-020 With rst_n=0 at a clk edge, the block SHALL enter IDLE, clear both counters, and drive every output to 0, including weights_valid.
REQ-021 Reset SHALL override abort and start, including mid-LOAD and mid-EMIT.

Verification
REQ-022 LOAD with cfg_out_last=3 -> load_ena high exactly 8 cycles; done and weights_valid rise on the cycle load_ena falls; busy high for 8 cycles.
REQ-023 RUN before any load -> err one cycle, busy stays 0, no act_ready.
REQ-024 RUN with cfg_out_last=2, cfg_vec_last=1, res_ready always 1 -> per vector: mac_clear 1 cycle, mac_en 3 cycles with col_idx 0,1,2, res_col 0,1,2; done after the 2nd vector's col 2.
REQ-025 EMIT with res_ready low for 5 cycles at res_col=1 -> res_valid and res_col=1 held stable; advance to 2 on the first res_ready=1 edge.
REQ-026 abort on the 3rd cycle of LOAD -> IDLE next edge, load_ena 0, weights_valid 0, no done.
REQ-027 rst_n low during MAC -> all outputs 0 next edge; a subsequent RUN start gives err.

Source files
------------

// File: rtl/ternary_seq_ctrl.sv
// Sequencer for a ternary-weight MAC array: weight load, per-vector accumulate, result emit.
// Every output is a flop; configuration is captured once per accepted start.
module ternary_seq_ctrl #(
  parameter int MAX_IN_LEN  = 16,
  parameter int MAX_OUT_LEN = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mode,
  input  logic       abort,
  input  logic [3:0] cfg_in_len,
  input  logic [2:0] cfg_out_last,
  input  logic [3:0] cfg_vec_last,
  output logic       load_ena,
  output logic       weights_valid,
  input  logic       act_valid,
  output logic       act_ready,
  output logic       mac_clear,
  output logic       mac_en,
  output logic [2:0] col_idx,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [2:0] res_col,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ACCEPT, S_MAC, S_EMIT} state_t;

  localparam logic [3:0] OUT_LAST_CAP = 4'(MAX_OUT_LEN - 1);
  localparam logic [4:0] IN_LEN_CAP   = 5'(MAX_IN_LEN);

  state_t     state_q, state_d;
  logic [3:0] beat_q, beat_d;
  logic [3:0] vec_q, vec_d;
  logic [2:0] out_last_q, out_last_d;
  logic [3:0] vec_last_q, vec_last_d;
  // Row count belongs to the datapath; kept here only so it is frozen per command.
  logic [3:0] unused_in_len_q, unused_in_len_d;
  logic       load_ena_q, load_ena_d;
  logic       weights_valid_q, weights_valid_d;
  logic       act_ready_q, act_ready_d;
  logic       mac_clear_q, mac_clear_d;
  logic       mac_en_q, mac_en_d;
  logic [2:0] col_idx_q, col_idx_d;
  logic       res_valid_q, res_valid_d;
  logic [2:0] res_col_q, res_col_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic [2:0] cap_out_last;
  logic [3:0] cap_in_len;

  assign cap_out_last = ({1'b0, cfg_out_last} > OUT_LAST_CAP) ? OUT_LAST_CAP[2:0] : cfg_out_last;
  assign cap_in_len   = ({1'b0, cfg_in_len} > IN_LEN_CAP) ? IN_LEN_CAP[3:0] : cfg_in_len;

  always_comb begin
    state_d         = state_q;
    beat_d          = beat_q;
    vec_d           = vec_q;
    out_last_d      = out_last_q;
    vec_last_d      = vec_last_q;
    unused_in_len_d = unused_in_len_q;
    load_ena_d      = 1'b0;
    weights_valid_d = weights_valid_q;
    act_ready_d     = 1'b0;
    mac_clear_d     = 1'b0;
    mac_en_d        = 1'b0;
    col_idx_d       = 3'd0;
    res_valid_d     = 1'b0;
    res_col_d       = 3'd0;
    done_d          = 1'b0;
    err_d           = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
      if (state_q == S_LOAD) weights_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (!mode || weights_valid_q) begin
              out_last_d      = cap_out_last;
              vec_last_d      = cfg_vec_last;
              unused_in_len_d = cap_in_len;
            end
            if (!mode) begin
              state_d         = S_LOAD;
              weights_valid_d = 1'b0;
              load_ena_d      = 1'b1;
              beat_d          = 4'd0;
            end else if (weights_valid_q) begin
              state_d     = S_ACCEPT;
              act_ready_d = 1'b1;
              vec_d       = 4'd0;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_LOAD: begin
          // Two beats (MSB, LSB) per column, so the last beat index is 2*out_last+1.
          if (beat_q == {out_last_q, 1'b1}) begin
            state_d         = S_IDLE;
            weights_valid_d = 1'b1;
            done_d          = 1'b1;
          end else begin
            beat_d     = beat_q + 4'd1;
            load_ena_d = 1'b1;
          end
        end
        S_ACCEPT: begin
          if (act_valid) begin
            state_d     = S_MAC;
            mac_clear_d = 1'b1;
          end else begin
            act_ready_d = 1'b1;
          end
        end
        S_MAC: begin
          // First MAC cycle carries the clear; accumulation starts on the next one.
          if (!mac_en_q) begin
            mac_en_d = 1'b1;
          end else if (col_idx_q == out_last_q) begin
            state_d     = S_EMIT;
            res_valid_d = 1'b1;
          end else begin
            mac_en_d  = 1'b1;
            col_idx_d = col_idx_q + 3'd1;
          end
        end
        S_EMIT: begin
          res_valid_d = 1'b1;
          res_col_d   = res_col_q;
          if (res_ready) begin
            if (res_col_q == out_last_q) begin
              res_valid_d = 1'b0;
              res_col_d   = 3'd0;
              if (vec_q == vec_last_q) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
              end else begin
                state_d     = S_ACCEPT;
                act_ready_d = 1'b1;
                vec_d       = vec_q + 4'd1;
              end
            end else begin
              res_col_d = res_col_q + 3'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      beat_q          <= 4'd0;
      vec_q           <= 4'd0;
      out_last_q      <= 3'd0;
      vec_last_q      <= 4'd0;
      unused_in_len_q <= 4'd0;
      load_ena_q      <= 1'b0;
      weights_valid_q <= 1'b0;
      act_ready_q     <= 1'b0;
      mac_clear_q     <= 1'b0;
      mac_en_q        <= 1'b0;
      col_idx_q       <= 3'd0;
      res_valid_q     <= 1'b0;
      res_col_q       <= 3'd0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      beat_q          <= beat_d;
      vec_q           <= vec_d;
      out_last_q      <= out_last_d;
      vec_last_q      <= vec_last_d;
      unused_in_len_q <= unused_in_len_d;
      load_ena_q      <= load_ena_d;
      weights_valid_q <= weights_valid_d;
      act_ready_q     <= act_ready_d;
      mac_clear_q     <= mac_clear_d;
      mac_en_q        <= mac_en_d;
      col_idx_q       <= col_idx_d;
      res_valid_q     <= res_valid_d;
      res_col_q       <= res_col_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      err_q           <= err_d;
    end
  end

  assign load_ena      = load_ena_q;
  assign weights_valid = weights_valid_q;
  assign act_ready     = act_ready_q;
  assign mac_clear     = mac_clear_q;
  assign mac_en        = mac_en_q;
  assign col_idx       = col_idx_q;
  assign res_valid     = res_valid_q;
  assign res_col       = res_col_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_ternary_seq_ctrl.sv
// Randomized bench for ternary_seq_ctrl: expected traces come from the command rules
// (beat counts, column/vector nested loops), sampled on the falling clock edge.
module tb_ternary_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start, mode, abort, act_valid, res_ready;
  logic [3:0] cfg_in_len, cfg_vec_last;
  logic [2:0] cfg_out_last;
  logic       load_ena, weights_valid, act_ready, mac_clear, mac_en;
  logic       res_valid, busy, done, err;
  logic [2:0] col_idx, res_col;
  logic [14:0] all_outs;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  ternary_seq_ctrl #(.MAX_IN_LEN(16), .MAX_OUT_LEN(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .abort(abort),
    .cfg_in_len(cfg_in_len), .cfg_out_last(cfg_out_last), .cfg_vec_last(cfg_vec_last),
    .load_ena(load_ena), .weights_valid(weights_valid),
    .act_valid(act_valid), .act_ready(act_ready),
    .mac_clear(mac_clear), .mac_en(mac_en), .col_idx(col_idx),
    .res_valid(res_valid), .res_ready(res_ready), .res_col(res_col),
    .busy(busy), .done(done), .err(err)
  );

  assign all_outs = {load_ena, weights_valid, act_ready, mac_clear, mac_en, col_idx,
                     res_valid, res_col, busy, done, err};

  task automatic idle_inputs();
    start = 0; mode = 0; abort = 0; act_valid = 0; res_ready = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    cfg_in_len = 4'd0; cfg_out_last = 3'd0; cfg_vec_last = 4'd0;
    rst_n = 0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (all_outs !== 15'd0) begin n_miss++; $display("FAIL reset_outputs got=%h want=0", all_outs); end
    rst_n = 1;
    @(negedge clk);
    n_vec++;
    if (all_outs !== 15'd0) begin n_miss++; $display("FAIL reset_idle got=%h want=0", all_outs); end
  endtask

  task automatic test_run_no_weights();
    int err_cnt = 0;
    bit first_err = 0, seen_busy = 0, seen_ardy = 0;
    @(negedge clk);
    start = 1; mode = 1; cfg_out_last = 3'($urandom); cfg_vec_last = 4'($urandom);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 0;
      if (err) err_cnt++;
      if (k == 1) first_err = err;
      if (busy) seen_busy = 1;
      if (act_ready) seen_ardy = 1;
    end
    n_vec++; if (first_err !== 1'b1) begin n_miss++; $display("FAIL noweights_err_first got=%b want=1", first_err); end
    n_vec++; if (err_cnt != 1) begin n_miss++; $display("FAIL noweights_err_len got=%0d want=1", err_cnt); end
    n_vec++; if (seen_busy) begin n_miss++; $display("FAIL noweights_busy got=1 want=0"); end
    n_vec++; if (seen_ardy) begin n_miss++; $display("FAIL noweights_act_ready got=1 want=0"); end
  endtask

  task automatic test_load(input int L);
    int n = 2 * (L + 1);
    int ena_cnt = 0, first_ena = 0, last_ena = 0, busy_cnt = 0;
    int done_cnt = 0, done_k = 0, wv_during = 0;
    logic wv_at_done = 0;
    @(negedge clk);
    start = 1; mode = 0; cfg_out_last = 3'(L); cfg_vec_last = 4'($urandom); cfg_in_len = 4'($urandom);
    for (int k = 1; k <= n + 4; k++) begin
      @(negedge clk);
      // A RUN command in the first LOAD cycle must be ignored.
      start = (k == 1); mode = 1;
      cfg_out_last = 3'($urandom); cfg_vec_last = 4'($urandom);
      if (load_ena) begin
        ena_cnt++; last_ena = k;
        if (first_ena == 0) first_ena = k;
        if (weights_valid) wv_during++;
      end
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_k = k; wv_at_done = weights_valid; end
    end
    idle_inputs();
    n_vec++; if (first_ena != 1) begin n_miss++; $display("FAIL load_first L=%0d got=%0d want=1", L, first_ena); end
    n_vec++; if (ena_cnt != n) begin n_miss++; $display("FAIL load_beats L=%0d got=%0d want=%0d", L, ena_cnt, n); end
    n_vec++; if (last_ena != n) begin n_miss++; $display("FAIL load_last L=%0d got=%0d want=%0d", L, last_ena, n); end
    n_vec++; if (busy_cnt != n) begin n_miss++; $display("FAIL load_busy L=%0d got=%0d want=%0d", L, busy_cnt, n); end
    n_vec++; if (done_cnt != 1) begin n_miss++; $display("FAIL load_done_cnt L=%0d got=%0d want=1", L, done_cnt); end
    n_vec++; if (done_k != n + 1) begin n_miss++; $display("FAIL load_done_when L=%0d got=%0d want=%0d", L, done_k, n + 1); end
    n_vec++; if (wv_at_done !== 1'b1) begin n_miss++; $display("FAIL load_wv_done L=%0d got=%b want=1", L, wv_at_done); end
    n_vec++; if (wv_during != 0) begin n_miss++; $display("FAIL load_wv_during L=%0d got=%0d want=0", L, wv_during); end
  endtask

  task automatic test_abort_priority();
    @(negedge clk);
    start = 1; mode = 0; abort = 1;
    @(negedge clk);
    idle_inputs();
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL abortprio_busy got=%b want=0", busy); end
    n_vec++; if (load_ena !== 1'b0) begin n_miss++; $display("FAIL abortprio_load_ena got=%b want=0", load_ena); end
    n_vec++; if (weights_valid !== 1'b1) begin n_miss++; $display("FAIL abortprio_wv got=%b want=1", weights_valid); end
  endtask

  task automatic test_run(input int L, input int V, input bit rnd_flow, input bit stall_col1);
    int total = (V + 1) * (L + 1);
    int budget = 300 + total * 30;
    int hs = 0, clr = 0, done_cnt = 0, done_k = -1, last_hs_k = -2, bad_col = 0, stall_n = 0, k = 0;
    bit prev_stall = 0, prev_b2b = 0, prev_act_hs = 0, fin = 0;
    logic [2:0] prev_col = 3'd0;
    int res_q[$];
    int mac_q[$];
    @(negedge clk);
    cfg_out_last = 3'(L); cfg_vec_last = 4'(V); cfg_in_len = 4'($urandom);
    mode = 1; start = 1; act_valid = 0; res_ready = 0;
    while (!fin && k < budget) begin
      @(negedge clk);
      k++;
      start = 0;
      cfg_out_last = 3'($urandom); cfg_vec_last = 4'($urandom); cfg_in_len = 4'($urandom);
      if (prev_stall) begin
        n_vec++;
        if (res_valid !== 1'b1 || res_col !== prev_col) begin
          n_miss++; $display("FAIL emit_hold got=%b/%0d want=1/%0d", res_valid, res_col, prev_col);
        end
      end
      if (prev_b2b) begin
        n_vec++;
        if (act_ready !== 1'b1) begin n_miss++; $display("FAIL back_to_back act_ready got=%b want=1", act_ready); end
      end
      if (prev_act_hs) begin
        n_vec++;
        if (mac_clear !== 1'b1) begin n_miss++; $display("FAIL mac_clear_after_accept got=%b want=1", mac_clear); end
      end
      if (mac_clear) clr++;
      if (mac_en) mac_q.push_back(int'(col_idx));
      else if (col_idx !== 3'd0) bad_col++;
      if (done) begin done_cnt++; done_k = k; end
      act_valid = rnd_flow ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (stall_col1 && res_valid && res_col == 3'd1 && stall_n < 5) begin
        res_ready = 0; stall_n++;
      end else begin
        res_ready = rnd_flow ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      prev_act_hs = act_ready && act_valid;
      prev_stall  = res_valid && !res_ready;
      prev_col    = res_col;
      prev_b2b    = 0;
      if (res_valid && res_ready) begin
        res_q.push_back(int'(res_col));
        hs++;
        if (hs == total) last_hs_k = k;
        else if (hs % (L + 1) == 0) prev_b2b = 1;
      end
      if (done_cnt > 0 && k > done_k + 2) fin = 1;
    end
    idle_inputs();
    if (!fin) begin n_vec++; n_miss++; $display("FAIL run_timeout L=%0d V=%0d got=%0d cycles want=done", L, V, k); end
    n_vec++; if (res_q.size() != total) begin n_miss++; $display("FAIL res_count L=%0d V=%0d got=%0d want=%0d", L, V, res_q.size(), total); end
    for (int i = 0; i < res_q.size(); i++) begin
      n_vec++;
      if (res_q[i] != i % (L + 1)) begin n_miss++; $display("FAIL res_col[%0d] got=%0d want=%0d", i, res_q[i], i % (L + 1)); end
    end
    n_vec++; if (mac_q.size() != total) begin n_miss++; $display("FAIL mac_count L=%0d V=%0d got=%0d want=%0d", L, V, mac_q.size(), total); end
    for (int i = 0; i < mac_q.size(); i++) begin
      n_vec++;
      if (mac_q[i] != i % (L + 1)) begin n_miss++; $display("FAIL col_idx[%0d] got=%0d want=%0d", i, mac_q[i], i % (L + 1)); end
    end
    n_vec++; if (clr != V + 1) begin n_miss++; $display("FAIL mac_clear_count got=%0d want=%0d", clr, V + 1); end
    n_vec++; if (done_cnt != 1) begin n_miss++; $display("FAIL run_done_cnt got=%0d want=1", done_cnt); end
    n_vec++; if (done_k != last_hs_k + 1) begin n_miss++; $display("FAIL run_done_when got=%0d want=%0d", done_k, last_hs_k + 1); end
    n_vec++; if (bad_col != 0) begin n_miss++; $display("FAIL col_idx_idle got=%0d nonzero want=0", bad_col); end
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL run_busy_end got=%b want=0", busy); end
  endtask

  task automatic test_abort_emit();
    bit seen = 0;
    @(negedge clk);
    cfg_out_last = 3'd2; cfg_vec_last = 4'd0; mode = 1; start = 1; act_valid = 1; res_ready = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      start = 0;
      if (res_valid) seen = 1;
    end
    n_vec++; if (!seen) begin n_miss++; $display("FAIL abort_emit_reach got=0 want=res_valid"); end
    @(negedge clk);
    abort = 1; start = 1; mode = 0;
    @(negedge clk);
    idle_inputs();
    n_vec++; if (res_valid !== 1'b0) begin n_miss++; $display("FAIL abort_emit_res_valid got=%b want=0", res_valid); end
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL abort_emit_busy got=%b want=0", busy); end
    n_vec++; if (weights_valid !== 1'b1) begin n_miss++; $display("FAIL abort_emit_wv got=%b want=1", weights_valid); end
    n_vec++; if (done !== 1'b0) begin n_miss++; $display("FAIL abort_emit_done got=%b want=0", done); end
    @(negedge clk);
    n_vec++; if (done !== 1'b0 || busy !== 1'b0) begin n_miss++; $display("FAIL abort_emit_after got=%b%b want=00", done, busy); end
  endtask

  task automatic test_abort_load();
    int ena_cnt = 0;
    @(negedge clk);
    start = 1; mode = 0; cfg_out_last = 3'd3;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      start = 0;
      if (load_ena) ena_cnt++;
      if (k == 3) abort = 1;
    end
    @(negedge clk);
    abort = 0;
    n_vec++; if (ena_cnt != 3) begin n_miss++; $display("FAIL abort_load_beats got=%0d want=3", ena_cnt); end
    n_vec++; if (load_ena !== 1'b0) begin n_miss++; $display("FAIL abort_load_ena got=%b want=0", load_ena); end
    n_vec++; if (weights_valid !== 1'b0) begin n_miss++; $display("FAIL abort_load_wv got=%b want=0", weights_valid); end
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL abort_load_busy got=%b want=0", busy); end
    n_vec++; if (done !== 1'b0) begin n_miss++; $display("FAIL abort_load_done got=%b want=0", done); end
    @(negedge clk);
    n_vec++; if (done !== 1'b0) begin n_miss++; $display("FAIL abort_load_done_late got=%b want=0", done); end
    start = 1; mode = 1;
    @(negedge clk);
    start = 0;
    n_vec++; if (err !== 1'b1) begin n_miss++; $display("FAIL abort_load_run_err got=%b want=1", err); end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    @(negedge clk);
    cfg_out_last = 3'd7; cfg_vec_last = 4'd0; mode = 1; start = 1; act_valid = 1; res_ready = 1;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      start = 0;
      if (mac_en) seen = 1;
    end
    n_vec++; if (!seen) begin n_miss++; $display("FAIL reset_mid_reach got=0 want=mac_en"); end
    rst_n = 0; abort = 1; start = 1; mode = 0;
    @(negedge clk);
    n_vec++; if (all_outs !== 15'd0) begin n_miss++; $display("FAIL reset_mid_outputs got=%h want=0", all_outs); end
    rst_n = 1; idle_inputs();
    @(negedge clk);
    start = 1; mode = 1;
    @(negedge clk);
    start = 0;
    n_vec++; if (err !== 1'b1) begin n_miss++; $display("FAIL reset_mid_run_err got=%b want=1", err); end
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL reset_mid_busy got=%b want=0", busy); end
  endtask

  initial begin
    test_reset();
    test_run_no_weights();
    test_load(3);
    test_load(0);
    test_load(7);
    test_load(int'($urandom_range(0, 7)));
    test_abort_priority();
    test_run(2, 1, 1'b0, 1'b0);
    test_run(2, 0, 1'b0, 1'b1);
    for (int t = 0; t < 4; t++) test_run(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 1'b1, 1'b0);
    test_run(7, 15, 1'b1, 1'b0);
    test_abort_emit();
    test_abort_load();
    test_load(1);
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
